// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin share of one valid/ready memory port between
// instruction fetch (A, read-only) and load/store (B), with response timeout.
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif

module mem_arbiter #(
   parameter int ADDR_WIDTH     = `RISCV_ADDR_WIDTH,
   parameter int WORD_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  a_valid_i,
   output logic                  a_ready_o,
   input  logic [ADDR_WIDTH-1:0] a_addr_i,
   output logic [WORD_WIDTH-1:0] a_rdata_o,
   input  logic                  b_valid_i,
   output logic                  b_ready_o,
   input  logic                  b_we_i,
   input  logic [3:0]            b_be_i,
   input  logic [ADDR_WIDTH-1:0] b_addr_i,
   input  logic [WORD_WIDTH-1:0] b_wdata_i,
   output logic [WORD_WIDTH-1:0] b_rdata_o,
   output logic                  err_o,
   output logic                  mem_valid_o,
   input  logic                  mem_ready_i,
   output logic                  mem_we_o,
   output logic [3:0]            mem_be_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [WORD_WIDTH-1:0] mem_wdata_o,
   input  logic [WORD_WIDTH-1:0] mem_rdata_i
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_e;

   typedef enum logic {
      GNT_A = 1'b0,
      GNT_B = 1'b1
   } gnt_e;

   state_e          state_q;
   gnt_e            grant_q;
   gnt_e            last_q;
   gnt_e            grant_d;
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   cnt_d;
   logic            tmo_d;

   // Contention goes to the port that did not win last time.
   always_comb begin
      grant_d = GNT_A;
      if (a_valid_i && b_valid_i) begin
         grant_d = (last_q == GNT_A) ? GNT_B : GNT_A;
      end else if (b_valid_i) begin
         grant_d = GNT_B;
      end
   end

   assign cnt_d = cnt_q + CW'(1);
   assign tmo_d = (cnt_d == CW'(TIMEOUT_CYCLES));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         grant_q     <= GNT_A;
         last_q      <= GNT_B;
         cnt_q       <= '0;
         a_ready_o   <= 1'b0;
         a_rdata_o   <= '0;
         b_ready_o   <= 1'b0;
         b_rdata_o   <= '0;
         err_o       <= 1'b0;
         mem_valid_o <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_be_o    <= '0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
      end else begin
         a_ready_o <= 1'b0;
         b_ready_o <= 1'b0;
         err_o     <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (a_valid_i || b_valid_i) begin
                  grant_q     <= grant_d;
                  last_q      <= grant_d;
                  mem_valid_o <= 1'b1;
                  state_q     <= S_ISSUE;
                  if (grant_d == GNT_B) begin
                     mem_we_o    <= b_we_i;
                     mem_be_o    <= b_be_i;
                     mem_addr_o  <= b_addr_i;
                     mem_wdata_o <= b_wdata_i;
                  end else begin
                     mem_we_o    <= 1'b0;
                     mem_be_o    <= 4'hF;
                     mem_addr_o  <= a_addr_i;
                     mem_wdata_o <= '0;
                  end
               end
            end
            S_ISSUE: begin
               mem_valid_o <= 1'b0;
               state_q     <= S_WAIT;
            end
            S_WAIT: begin
               cnt_q <= cnt_d;
               if (mem_ready_i) begin
                  state_q <= S_RESP;
                  if (grant_q == GNT_A) begin
                     a_ready_o <= 1'b1;
                     a_rdata_o <= mem_rdata_i;
                  end else begin
                     b_ready_o <= 1'b1;
                     b_rdata_o <= mem_we_o ? '0 : mem_rdata_i;
                  end
               end else if (tmo_d) begin
                  state_q <= S_RESP;
                  err_o   <= 1'b1;
                  if (grant_q == GNT_A) begin
                     a_ready_o <= 1'b1;
                     a_rdata_o <= '0;
                  end else begin
                     b_ready_o <= 1'b1;
                     b_rdata_o <= '0;
                  end
               end
            end
            S_RESP: begin
               cnt_q       <= '0;
               mem_we_o    <= 1'b0;
               mem_be_o    <= '0;
               mem_addr_o  <= '0;
               mem_wdata_o <= '0;
               state_q     <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
